// File: rtl/dotprod_scheduler_if.sv
// Requester-side handshake between the gate/cell control logic and the shared
// dot_prod scheduler.
interface dotprod_scheduler_if #(
  parameter int NREQ           = 4,
  parameter int LAYER_BITWIDTH = 288
);
  logic [NREQ-1:0]           req;
  logic [NREQ-1:0]           ack;
  logic [NREQ-1:0]           done;
  logic [LAYER_BITWIDTH-1:0] resultData;
  logic                      timeoutErr;

  modport master (output req, input ack, input done, input resultData, input timeoutErr);
  modport slave  (input req, output ack, output done, output resultData, output timeoutErr);
endinterface

// File: rtl/dotprod_scheduler.sv
// Round-robin scheduler sharing one dot_prod engine between NREQ requesters:
// grants, steers the weight bank, restarts the engine and returns its result.
module dotprod_scheduler #(
  parameter  int NREQ           = 4,
  parameter  int NROW           = 16,
  parameter  int QN             = 6,
  parameter  int QM             = 11,
  parameter  int TIMEOUT        = 255,
  localparam int BITWIDTH       = QN + QM + 1,
  localparam int LAYER_BITWIDTH = BITWIDTH * NROW,
  localparam int SEL_BITWIDTH   = $clog2(NREQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  dotprod_scheduler_if.slave        sched,
  output logic                      engReset,
  output logic [SEL_BITWIDTH-1:0]   engSel,
  input  logic                      engDataReady,
  input  logic [LAYER_BITWIDTH-1:0] engOutput,
  output logic                      busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [2:0] {IDLE, GRANT, START, RUN, CAPTURE, DONE} state_t;

  state_t                    state;
  logic [SEL_BITWIDTH-1:0]   ptr;
  logic [CNT_W-1:0]          cnt;
  logic [NREQ-1:0]           ack_pulse;
  logic [NREQ-1:0]           done_pulse;
  logic [LAYER_BITWIDTH-1:0] result;
  logic                      timeout_flag;

  logic                      found;
  logic [SEL_BITWIDTH-1:0]   gsel;
  logic [SEL_BITWIDTH-1:0]   idx;

  always_comb begin
    found = 1'b0;
    gsel  = '0;
    idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = ptr + SEL_BITWIDTH'(i);
      if (!found && sched.req[idx]) begin
        found = 1'b1;
        gsel  = idx;
      end
    end
  end

  // The winner is sampled in IDLE so the ack pulse is a register that is high
  // during GRANT; requests that vanish before sampling simply keep us in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      ptr          <= '0;
      cnt          <= '0;
      ack_pulse    <= '0;
      done_pulse   <= '0;
      result       <= '0;
      timeout_flag <= 1'b0;
      engReset     <= 1'b1;
      engSel       <= '0;
      busy         <= 1'b0;
    end else begin
      ack_pulse  <= '0;
      done_pulse <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            state        <= GRANT;
            ack_pulse    <= ONE << gsel;
            engSel       <= gsel;
            ptr          <= gsel + SEL_BITWIDTH'(1);
            timeout_flag <= 1'b0;
            busy         <= 1'b1;
          end
        end
        GRANT: state <= START;
        START: begin
          state    <= RUN;
          cnt      <= '0;
          engReset <= 1'b0;
        end
        RUN: begin
          if (engDataReady) begin
            state    <= CAPTURE;
            engReset <= 1'b1;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state        <= DONE;
            engReset     <= 1'b1;
            timeout_flag <= 1'b1;
            result       <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        CAPTURE: begin
          result <= engOutput;
          state  <= DONE;
        end
        DONE: begin
          done_pulse <= ONE << engSel;
          state      <= IDLE;
          busy       <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign sched.ack        = ack_pulse;
  assign sched.done       = done_pulse;
  assign sched.resultData = result;
  assign sched.timeoutErr = timeout_flag;

endmodule

// File: tb/tb_dotprod_scheduler.sv
// Scoreboard bench for dotprod_scheduler: stimulus queues expected grants and
// completions, a negedge monitor pops and compares them.
module tb_dotprod_scheduler;

  localparam int NREQ    = 4;
  localparam int LW      = 18 * 16;
  localparam int TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          engReset;
  logic [1:0]    engSel;
  logic          engDataReady = 1'b0;
  logic [LW-1:0] engOutput = '0;
  logic          busy;

  dotprod_scheduler_if #(.NREQ(NREQ), .LAYER_BITWIDTH(LW)) sched ();

  dotprod_scheduler #(.NREQ(NREQ), .NROW(16), .QN(6), .QM(11), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .sched(sched), .engReset(engReset), .engSel(engSel),
    .engDataReady(engDataReady), .engOutput(engOutput), .busy(busy)
  );

  typedef struct { int idx; int cyc; } ack_t;
  typedef struct { int idx; logic [LW-1:0] data; logic terr; int lat; } done_t;

  ack_t  exp_ack[$];
  done_t exp_done[$];

  int total = 0;
  int passed = 0;
  int cyc = 0;
  int ack_cyc = 0;
  int ready_after = 0;
  logic spur = 1'b0;
  logic hold = 1'b0;

  logic [LW-1:0] pat_a, pat_b, pat_c, pat_d, pat_e, pat_f;

  function automatic void chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic void chk_reset_values(input string tag);
    chk({tag, "_ack"}, sched.ack, 0);
    chk({tag, "_done"}, sched.done, 0);
    chk({tag, "_result"}, sched.resultData, 0);
    chk({tag, "_terr"}, sched.timeoutErr, 0);
    chk({tag, "_eng_reset"}, engReset, 1);
    chk({tag, "_eng_sel"}, engSel, 0);
    chk({tag, "_busy"}, busy, 0);
  endfunction

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cyc++; end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  // Engine model: strobes ready in the ready_after-th cycle out of reset.
  initial begin
    int run_cnt = 0;
    forever begin
      @(negedge clk);
      if (engReset) begin
        run_cnt = 0;
        engDataReady = spur;
      end else begin
        run_cnt++;
        engDataReady = (ready_after != 0) && (run_cnt == ready_after);
      end
    end
  end

  // Requesters drop their line once acknowledged unless told to hold it.
  initial forever begin
    @(negedge clk);
    if (!hold) sched.req = sched.req & ~sched.ack;
  end

  initial begin
    ack_t  a;
    done_t d;
    forever begin
      @(negedge clk);
      if (|sched.ack) begin
        if (exp_ack.size() == 0) chk("unexpected_ack", sched.ack, 0);
        else begin
          a = exp_ack.pop_front();
          chk("ack_onehot", sched.ack, 1 << a.idx);
          chk("ack_eng_sel", engSel, a.idx);
          chk("ack_terr_clear", sched.timeoutErr, 0);
          chk("ack_busy", busy, 1);
          if (a.cyc >= 0) chk("ack_cycle", cyc, a.cyc);
          ack_cyc = cyc;
        end
      end
      if (|sched.done) begin
        if (exp_done.size() == 0) chk("unexpected_done", sched.done, 0);
        else begin
          d = exp_done.pop_front();
          chk("done_onehot", sched.done, 1 << d.idx);
          chk("done_result", sched.resultData, d.data);
          chk("done_terr", sched.timeoutErr, d.terr);
          chk("done_latency", cyc - ack_cyc, d.lat);
          chk("done_busy", busy, 0);
        end
      end
    end
  end

  task automatic push_ack(input int idx, input int c);
    ack_t a;
    a.idx = idx; a.cyc = c;
    exp_ack.push_back(a);
  endtask

  task automatic push_done(input int idx, input logic [LW-1:0] data, input logic terr, input int lat);
    done_t d;
    d.idx = idx; d.data = data; d.terr = terr; d.lat = lat;
    exp_done.push_back(d);
  endtask

  task automatic drain(input string name, input int maxc);
    int n = 0;
    while ((exp_ack.size() != 0 || exp_done.size() != 0) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_drained"}, (n < maxc), 1);
  endtask

  initial begin
    pat_a = {18{16'h1234}};
    pat_b = {36{8'hA5}};
    pat_c = {9{32'hDEADBEEF}};
    pat_d = {18{16'h0F1E}};
    pat_e = {72{4'h7}};
    pat_f = {18{16'hC3C3}};
    sched.req = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    reset = 1'b1;
    @(negedge clk);

    // Single job: requester 0, ready in 10th RUN cycle
    engOutput = pat_a; ready_after = 10;
    push_ack(0, cyc + 1);
    push_done(0, pat_a, 1'b0, 14);
    sched.req = 4'b0001;
    drain("single", 60);

    // Fresh pointer, all four requesting continuously
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    engOutput = pat_b; ready_after = 3; hold = 1'b1;
    for (int j = 0; j < 5; j++) begin
      push_ack(j % NREQ, cyc + 1 + 8 * j);
      push_done(j % NREQ, pat_b, 1'b0, 7);
    end
    sched.req = 4'b1111;
    begin
      int n = 0;
      while (exp_ack.size() != 0 && n < 100) begin @(negedge clk); n++; end
    end
    sched.req = '0; hold = 1'b0;
    drain("rr_all", 100);

    // Serve requester 1, then wrap-around 0 before 1
    engOutput = pat_c; ready_after = 2;
    push_ack(1, cyc + 1);
    push_done(1, pat_c, 1'b0, 6);
    sched.req = 4'b0010;
    drain("serve1", 40);
    push_ack(0, cyc + 1);
    push_done(0, pat_c, 1'b0, 6);
    push_ack(1, cyc + 8);
    push_done(1, pat_c, 1'b0, 6);
    sched.req = 4'b0011;
    drain("wrap", 60);

    // Timeout abort, then the next grant clears the error
    ready_after = 0; engOutput = pat_d;
    push_ack(2, cyc + 1);
    push_done(2, '0, 1'b1, TIMEOUT + 3);
    sched.req = 4'b0100;
    drain("timeout", TIMEOUT + 40);
    @(negedge clk);
    chk("terr_held", sched.timeoutErr, 1);
    ready_after = 5;
    push_ack(3, cyc + 1);
    push_done(3, pat_d, 1'b0, 9);
    sched.req = 4'b1000;
    drain("after_timeout", 40);

    // Asynchronous reset in the middle of RUN abandons the job
    ready_after = 50; engOutput = pat_e;
    push_ack(1, cyc + 1);
    sched.req = 4'b0010;
    begin
      int n = 0;
      while (engReset !== 1'b0 && n < 20) begin @(negedge clk); n++; end
      chk("reached_run", engReset, 0);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
    sched.req = 4'b0100;
    #1;
    chk_reset_values("async_reset");
    repeat (2) @(negedge clk);
    ready_after = 4; engOutput = pat_f;
    push_ack(2, cyc + 1);
    push_done(2, pat_f, 1'b0, 8);
    reset = 1'b1;
    drain("post_reset", 40);

    // Spurious ready strobes outside RUN are ignored
    spur = 1'b1;
    repeat (5) @(negedge clk);
    chk("spur_idle_result", sched.resultData, pat_f);
    chk("spur_idle_busy", busy, 0);
    ready_after = 6; engOutput = pat_e;
    push_ack(0, cyc + 1);
    push_done(0, pat_e, 1'b0, 10);
    sched.req = 4'b0001;
    drain("spurious", 40);
    spur = 1'b0;
    repeat (4) @(negedge clk);

    chk("ack_queue_empty", exp_ack.size(), 0);
    chk("done_queue_empty", exp_done.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
